// File: rtl/clk_div_n.sv
// -----------------------------------------------------------------------------
// clk_div_n
//   Runtime-programmable integer clock divider. It produces a 50%-duty divided
//   clock for even and odd divisors, a one-cycle strobe at the start of each
//   output period, and a one-cycle error pulse when a divisor request is
//   rejected. A new divisor is only adopted at a period boundary, so clk_out
//   never glitches.
//
// Ports
//   clk        in   source clock (posedge logic plus one negedge flop)
//   rst        in   synchronous active-high reset
//   en         in   count enable; low freezes the divider and holds clk_out
//   load       in   one-cycle strobe requesting a new divisor
//   div_val    in   requested divisor, sampled when load = 1 (must be >= 2)
//   clk_out    out  divided clock, N/2 source periods high
//   tick       out  high for the source cycle in which clk_out rises
//   err        out  one-cycle pulse after a rejected load (div_val < 2)
//   div_active out  divisor currently in use
// -----------------------------------------------------------------------------
module clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             err,
    output logic [WIDTH-1:0] div_active
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend_div;
    logic             pending;
    logic             q_pos;
    logic             q_neg;

    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] half_next;

    // NOTE: every signal gets a value on every path through always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        wrap     = (cnt == div_active - ONE);
        apply    = wrap & pending;
        // The period that starts on this edge already uses the new divisor.
        n_next   = apply ? pend_div : div_active;
        cnt_next = wrap ? '0 : cnt + ONE;
        // ceil(N/2) written as floor(N/2) + lsb so that N = 2^WIDTH-1 does
        // not overflow the WIDTH-bit arithmetic.
        half_next = (n_next >> 1) + {{(WIDTH-1){1'b0}}, n_next[0]};
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= DEF_DIV - ONE;
            div_active <= DEF_DIV;
            pend_div   <= DEF_DIV;
            pending    <= 1'b0;
            q_pos      <= 1'b0;
            tick       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;

            if (en) begin
                cnt   <= cnt_next;
                q_pos <= (cnt_next < half_next);
                tick  <= wrap;
                if (apply) begin
                    div_active <= pend_div;
                    pending    <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end

            // Loads are accepted even while frozen. A load on the apply edge
            // is written after the apply above, so it becomes the next
            // pending request rather than being lost.
            if (load) begin
                if (div_val >= TWO) begin
                    pend_div <= div_val;
                    pending  <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Half-cycle delayed copy of q_pos; ANDing it in trims the odd-N high
    // phase from (N+1)/2 to N/2 source periods. When frozen it simply copies
    // the held q_pos, so clk_out keeps its level.
    always_ff @(negedge clk) begin
        if (rst) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    // Parity comes from the registered divisor, so the path choice only
    // changes at the same edge that starts the new period.
    assign clk_out = div_active[0] ? (q_pos & q_neg) : q_pos;

endmodule

// File: tb/tb_clk_div_n.sv
`timescale 1ns/100ps
module tb_clk_div_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] div_val;
    logic       clk_out;
    logic       tick;
    logic       err;
    logic [7:0] div_active;

    int checks   = 0;
    int failures = 0;

    // Samples of the last source cycle: tick/err/div_active just after the
    // posedge, and the number of half-cycles clk_out was seen high.
    int   s_hi;
    logic s_tick;
    logic s_err;
    logic [7:0] s_da;

    clk_div_n #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .div_val    (div_val),
        .clk_out    (clk_out),
        .tick       (tick),
        .err        (err),
        .div_active (div_active)
    );

    always #1 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #0.5;
        s_tick = tick;
        s_err  = err;
        s_da   = div_active;
        s_hi   = (clk_out === 1'b1) ? 1 : 0;
        @(negedge clk);
        #0.5;
        s_hi   = s_hi + ((clk_out === 1'b1) ? 1 : 0);
    endtask

    // Measures one output period starting at a tick cycle (the current one
    // if it already is). Leaves the bench on the next tick cycle.
    // per = -1 when a bound expires.
    task automatic measure(output int per, output int hi);
        int b;
        b = 0;
        while (s_tick !== 1'b1 && b < 600) begin
            cyc();
            b++;
        end
        per = 1;
        hi  = s_hi;
        if (b >= 600) begin
            per = -1;
            return;
        end
        b = 0;
        forever begin
            cyc();
            if (s_tick === 1'b1) break;
            per++;
            hi += s_hi;
            b++;
            if (b >= 600) begin
                per = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int per, hi;
        rst = 1'b1; en = 1'b1; load = 1'b0; div_val = '0;
        cyc();
        cyc();
        checks++; if (s_hi !== 0) begin failures++; $display("FAIL reset_clk_out got=%0d exp=0", s_hi); end
        checks++; if (s_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", s_tick); end
        checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", s_err); end
        checks++; if (s_da !== 8'd3) begin failures++; $display("FAIL reset_div_active got=%0d exp=3", s_da); end
        rst = 1'b0;
        cyc();
        checks++; if (s_tick !== 1'b1) begin failures++; $display("FAIL reset_first_tick got=%b exp=1", s_tick); end
        measure(per, hi);
        checks++; if (per !== 3) begin failures++; $display("FAIL div3_period got=%0d exp=3", per); end
        checks++; if (hi !== 3) begin failures++; $display("FAIL div3_high_halves got=%0d exp=3", hi); end
        measure(per, hi);
        checks++; if (per !== 3 || hi !== 3) begin failures++; $display("FAIL div3_period2 got=%0d/%0d exp=3/3", per, hi); end
    endtask

    task automatic test_load_even();
        int per, hi;
        load = 1'b1; div_val = 8'd4;
        cyc();
        load = 1'b0;
        cyc();
        checks++; if (s_tick !== 1'b0 || s_da !== 8'd3) begin failures++; $display("FAIL load4_before_wrap got tick=%b da=%0d exp tick=0 da=3", s_tick, s_da); end
        cyc();
        checks++; if (s_tick !== 1'b1) begin failures++; $display("FAIL load4_old_period_end got=%b exp=1", s_tick); end
        checks++; if (s_da !== 8'd4) begin failures++; $display("FAIL load4_apply got=%0d exp=4", s_da); end
        measure(per, hi);
        checks++; if (per !== 4) begin failures++; $display("FAIL div4_period got=%0d exp=4", per); end
        checks++; if (hi !== 4) begin failures++; $display("FAIL div4_high_halves got=%0d exp=4", hi); end
    endtask

    task automatic test_last_wins();
        int per, hi;
        load = 1'b1; div_val = 8'd5;
        cyc();
        div_val = 8'd7;
        cyc();
        load = 1'b0;
        checks++; if (s_da !== 8'd4) begin failures++; $display("FAIL last_wins_hold got=%0d exp=4", s_da); end
        measure(per, hi);
        checks++; if (s_da !== 8'd7) begin failures++; $display("FAIL last_wins_value got=%0d exp=7", s_da); end
        checks++; if (per !== 7) begin failures++; $display("FAIL div7_period got=%0d exp=7", per); end
        checks++; if (hi !== 7) begin failures++; $display("FAIL div7_high_halves got=%0d exp=7", hi); end
    endtask

    task automatic test_err();
        int per, hi;
        load = 1'b1; div_val = 8'd1;
        cyc();
        checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL err_div1 got=%b exp=1", s_err); end
        div_val = 8'd0;
        cyc();
        load = 1'b0;
        checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL err_div0 got=%b exp=1", s_err); end
        cyc();
        checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", s_err); end
        measure(per, hi);
        checks++; if (per !== 7 || hi !== 7) begin failures++; $display("FAIL err_period got=%0d/%0d exp=7/7", per, hi); end
        checks++; if (s_da !== 8'd7) begin failures++; $display("FAIL err_div_active got=%0d exp=7", s_da); end
    endtask

    task automatic test_en_freeze();
        int per, hi, b;
        per = 1;
        hi  = s_hi;
        cyc();
        per++;
        hi += s_hi;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            per++;
            hi += s_hi;
            checks++; if (s_hi !== 2 || s_tick !== 1'b0) begin failures++; $display("FAIL freeze_hold[%0d] got hi=%0d tick=%b exp hi=2 tick=0", i, s_hi, s_tick); end
        end
        en = 1'b1;
        b = 0;
        forever begin
            cyc();
            if (s_tick === 1'b1 || b >= 100) break;
            per++;
            hi += s_hi;
            b++;
        end
        checks++; if (per !== 12) begin failures++; $display("FAIL freeze_period got=%0d exp=12", per); end
        checks++; if (hi !== 17) begin failures++; $display("FAIL freeze_high_halves got=%0d exp=17", hi); end
    endtask

    task automatic test_reset_mid();
        int per, hi;
        cyc();
        load = 1'b1; div_val = 8'd5;
        cyc();
        load = 1'b0;
        rst = 1'b1;
        cyc();
        checks++; if (s_hi !== 0 || s_tick !== 1'b0) begin failures++; $display("FAIL rst_mid_out got hi=%0d tick=%b exp 0/0", s_hi, s_tick); end
        checks++; if (s_da !== 8'd3) begin failures++; $display("FAIL rst_mid_div_active got=%0d exp=3", s_da); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (s_tick !== 1'b1) begin failures++; $display("FAIL rst_mid_first_tick got=%b exp=1", s_tick); end
        measure(per, hi);
        checks++; if (per !== 3 || hi !== 3) begin failures++; $display("FAIL rst_mid_period1 got=%0d/%0d exp=3/3", per, hi); end
        measure(per, hi);
        checks++; if (per !== 3 || hi !== 3) begin failures++; $display("FAIL rst_mid_pending_cleared got=%0d/%0d exp=3/3", per, hi); end
    endtask

    task automatic test_back_to_back();
        int per, hi;
        cyc();
        cyc();
        load = 1'b1; div_val = 8'd2;
        cyc();
        load = 1'b0;
        checks++; if (s_tick !== 1'b1 || s_da !== 8'd3) begin failures++; $display("FAIL load_at_wrap got tick=%b da=%0d exp tick=1 da=3", s_tick, s_da); end
        measure(per, hi);
        checks++; if (per !== 3 || hi !== 3) begin failures++; $display("FAIL load_at_wrap_old got=%0d/%0d exp=3/3", per, hi); end
        checks++; if (s_da !== 8'd2) begin failures++; $display("FAIL load_at_wrap_apply got=%0d exp=2", s_da); end
        measure(per, hi);
        checks++; if (per !== 2 || hi !== 2) begin failures++; $display("FAIL div2_period got=%0d/%0d exp=2/2", per, hi); end
    endtask

    task automatic test_max_div();
        int per, hi;
        load = 1'b1; div_val = 8'd255;
        cyc();
        load = 1'b0;
        measure(per, hi);
        checks++; if (s_da !== 8'd255) begin failures++; $display("FAIL div255_active got=%0d exp=255", s_da); end
        checks++; if (per !== 255 || hi !== 255) begin failures++; $display("FAIL div255_period got=%0d/%0d exp=255/255", per, hi); end
        load = 1'b1; div_val = 8'd255;
        cyc();
        load = 1'b0;
        measure(per, hi);
        checks++; if (per !== 255 || hi !== 255 || s_da !== 8'd255) begin failures++; $display("FAIL same_value_load got=%0d/%0d da=%0d exp=255/255 da=255", per, hi, s_da); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; div_val = '0;
        s_hi = 0; s_tick = 1'b0; s_err = 1'b0; s_da = '0;
        test_reset();
        test_load_even();
        test_last_wins();
        test_err();
        test_en_freeze();
        test_reset_mid();
        test_back_to_back();
        test_max_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
